ascon_sequencer: RTL and testbench
==================================

# ascon_sequencer

Round-level controller for the Ascon-128 encryption/decryption/hash datapath. Accepts one operation request at a time through a valid/ready handshake and drives the core's one-hot mode lines and a 7-bit cumulative round `count`. It also sequences the permutation phases (init, associated data, text, finalization, hash absorb/squeeze) and reports completion and tag-check status. It replaces the free-running counter that sits beside the core in the top level.

## Interface

- `ROUNDS_A`, 12, rounds of p^a (init, finalization, every hash permutation)
- `ROUNDS_B`, 6, rounds of p^b (AD and text blocks)
- `AD_BLOCKS`, 4, 64-bit associated-data blocks per operation (legal 1..4)
- `PT_BLOCKS`, 4, 64-bit text blocks per operation (legal 1..4)
- `HASH_BLOCKS`, 4, 64-bit message blocks absorbed in hash mode (legal 1..4)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: operation request
- `req_op` in 2: 00 encrypt, 01 decrypt, 10 hash, 11 illegal
- `req_ready` out 1: high only in IDLE
- `tag_match` in 1: core tag comparator result, sampled in DONE
- `core_enc`, `core_dec`, `core_hash` out 1 each: one-hot mode, held for the whole operation
- `rnd_en` out 1: core performs one round this cycle
- `count` out 7: cumulative round index of the current operation
- `rnd_idx` out 4: round within the current permutation
- `blk_idx` out 2: block within the current AD/TEXT/ABSORB/SQUEEZE phase
- `phase` out 3: 0 IDLE, 1 INIT, 2 AD, 3 TEXT, 4 FINAL, 5 ABSORB, 6 SQUEEZE, 7 DONE
- `busy` out 1: state is not IDLE
- `done` out 1: single-cycle completion pulse
- `auth_fail` out 1: decrypt tag mismatch
- `err_illegal` out 1: last request was illegal

## Operation

- Accept occurs when `req_valid & req_ready` is high at a clock edge. `req_op` is latched at accept, and `req_valid` is ignored until the next IDLE.
- Accept also clears `auth_fail` and `err_illegal`.
- Encrypt/decrypt phase sequence:
  - INIT: `ROUNDS_A` rounds.
  - AD: `AD_BLOCKS` × `ROUNDS_B` rounds.
  - TEXT: (`PT_BLOCKS`−1) × `ROUNDS_B` rounds. The last text block has no p^b. If `PT_BLOCKS`=1, TEXT is skipped and the sequencer goes straight to FINAL.
  - FINAL: `ROUNDS_A` rounds.
  - DONE.
- Hash phase sequence:
  - INIT: `ROUNDS_A` rounds.
  - ABSORB: `HASH_BLOCKS` × `ROUNDS_A` rounds.
  - SQUEEZE: 3 × `ROUNDS_A` rounds (256-bit digest).
  - DONE.
- Illegal op: go from IDLE directly to DONE. No rounds; `err_illegal` set.
- Counters in every round phase:
  - `rnd_en` is 1.
  - `count` increments by 1 per round, starting at 0 in the first INIT cycle. It is not reset between phases.
  - `rnd_idx` runs 0..R−1 and wraps to 0 at each permutation boundary.
  - At each wrap `blk_idx` increments. `blk_idx` returns to 0 on every phase change.
- DONE lasts one cycle:
  - `done`=1.
  - `auth_fail` = ~`tag_match` if the op is decrypt, else 0.
  - Next state is IDLE.
- `auth_fail` and `err_illegal` hold until the next accept.
- Mode lines are high from the first cycle after accept through DONE, and 0 in IDLE.
- `count` holds its final value in DONE and IDLE until the next accept.
- Parameter rule: all round totals must be ≤127. The defaults give 66 (encrypt/decrypt) and 96 (hash).

## Timing

- Reset values, one edge after `rst`: state IDLE, `req_ready`=1, and every other output 0 (`count`, `rnd_idx`, `blk_idx`, `phase` all 0).
- `rst` asserted mid-operation: IDLE at the next edge with the values above. No `done` pulse.
- Accept at edge E, encrypt/decrypt with defaults:
  - `rnd_en` high in cycles E+1..E+66.
  - `done` high in cycle E+67.
  - `req_ready` high in cycle E+68.
- Hash with defaults: `rnd_en` high in E+1..E+96; `done` in E+97.
- Illegal op: `done` in E+1.
- No bubble cycles between phases. `phase` changes in the same cycle as the first round of the new phase.
- All outputs are registered.

## Configuration

- `ASCON_SEQ_HASH_EN` defined: hash op (`req_op`=10) supported as above.
- Not defined: ABSORB and SQUEEZE logic is removed, `core_hash` is tied to 0, and `req_op`=10 is handled exactly like 11 (`done` at E+1, `err_illegal`=1).

## Test plan

- Reset: hold `rst` 2 cycles → `req_ready`=1, `busy`=0, `count`=0, `phase`=0, `done`=0; reassert `rst` at E+30 of an encrypt → IDLE and `req_ready`=1 at E+31, no `done`.
- Encrypt with defaults → `core_enc`=1 E+1..E+67; `phase` 1 for 12 cycles, 2 for 24, 3 for 18, 4 for 12; `count` 0..65; `done` at E+67; `auth_fail`=0.
- Decrypt with `tag_match`=0 → `auth_fail`=1 from E+68 until next accept; repeat with `tag_match`=1 → `auth_fail`=0.
- Hash (macro defined) → `phase` 1 for 12 cycles, 5 for 48, 6 for 36; `blk_idx` 0..3 in ABSORB and 0..2 in SQUEEZE; `count` reaches 95; `done` at E+97.
- `req_op`=11 (and 10 with macro undefined) → `done` at E+1, `err_illegal`=1, `rnd_en` never high.
- `PT_BLOCKS`=1 encrypt → no phase 3; `done` at E+49 (12+24+12 rounds).

Source files
------------

// File: rtl/ascon_sequencer.sv
// Round/phase controller for the Ascon-128 core: one op per valid/ready handshake, registered outputs.
// Hash (ABSORB/SQUEEZE) support is compiled in only when ASCON_SEQ_HASH_EN is defined.
module ascon_sequencer #(
  parameter int ROUNDS_A    = 12,
  parameter int ROUNDS_B    = 6,
  parameter int AD_BLOCKS   = 4,
  parameter int PT_BLOCKS   = 4,
  parameter int HASH_BLOCKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  input  logic       tag_match,
  output logic       core_enc,
  output logic       core_dec,
  output logic       core_hash,
  output logic       rnd_en,
  output logic [6:0] count,
  output logic [3:0] rnd_idx,
  output logic [1:0] blk_idx,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done,
  output logic       auth_fail,
  output logic       err_illegal
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_AD      = 3'd2,
    S_TEXT    = 3'd3,
    S_FINAL   = 3'd4,
    S_ABSORB  = 3'd5,
    S_SQUEEZE = 3'd6,
    S_DONE    = 3'd7
  } phase_t;

  localparam logic [3:0] RA_LAST = 4'(ROUNDS_A - 1);
  localparam logic [3:0] RB_LAST = 4'(ROUNDS_B - 1);
  localparam logic [1:0] AD_LAST = 2'(AD_BLOCKS - 1);
  localparam logic [1:0] PT_LAST = 2'(PT_BLOCKS - 2);
  localparam logic [1:0] HB_LAST = 2'(HASH_BLOCKS - 1);

  phase_t     r_state;
  logic       r_ready, r_busy, r_done, r_rnd_en;
  logic       r_enc, r_dec, r_hash;
  logic       r_auth_fail, r_err_illegal;
  logic [6:0] r_count;
  logic [3:0] r_rnd_idx;
  logic [1:0] r_blk_idx;

  logic       w_rnd_last;
  logic       w_blk_last;
  phase_t     w_next;

  // Decode the end of the current permutation/phase and where the sequence goes next.
  always_comb begin
    w_rnd_last = 1'b0;
    w_blk_last = 1'b0;
    w_next     = S_DONE;
    case (r_state)
      S_INIT: begin
        w_rnd_last = (r_rnd_idx == RA_LAST);
        w_blk_last = 1'b1;
        w_next     = r_hash ? S_ABSORB : S_AD;
      end
      S_AD: begin
        w_rnd_last = (r_rnd_idx == RB_LAST);
        w_blk_last = (r_blk_idx == AD_LAST);
        w_next     = (PT_BLOCKS > 1) ? S_TEXT : S_FINAL;
      end
      S_TEXT: begin
        w_rnd_last = (r_rnd_idx == RB_LAST);
        w_blk_last = (r_blk_idx == PT_LAST);
        w_next     = S_FINAL;
      end
      S_FINAL: begin
        w_rnd_last = (r_rnd_idx == RA_LAST);
        w_blk_last = 1'b1;
      end
      S_ABSORB: begin
        w_rnd_last = (r_rnd_idx == RA_LAST);
        w_blk_last = (r_blk_idx == HB_LAST);
        w_next     = S_SQUEEZE;
      end
      S_SQUEEZE: begin
        w_rnd_last = (r_rnd_idx == RA_LAST);
        w_blk_last = (r_blk_idx == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rnd_en      <= 1'b0;
      r_enc         <= 1'b0;
      r_dec         <= 1'b0;
      r_hash        <= 1'b0;
      r_auth_fail   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_count       <= '0;
      r_rnd_idx     <= '0;
      r_blk_idx     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_ready       <= 1'b0;
            r_busy        <= 1'b1;
            r_auth_fail   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_count       <= '0;
            r_rnd_idx     <= '0;
            r_blk_idx     <= '0;
            r_state       <= S_INIT;
            r_rnd_en      <= 1'b1;
            case (req_op)
              2'b00: r_enc <= 1'b1;
              2'b01: r_dec <= 1'b1;
`ifdef ASCON_SEQ_HASH_EN
              2'b10: r_hash <= 1'b1;
`endif
              default: begin
                r_state       <= S_DONE;
                r_rnd_en      <= 1'b0;
                r_done        <= 1'b1;
                r_err_illegal <= 1'b1;
              end
            endcase
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_auth_fail <= r_dec & ~tag_match;
          r_enc       <= 1'b0;
          r_dec       <= 1'b0;
          r_hash      <= 1'b0;
        end
        default: begin
          if (w_rnd_last && w_blk_last) begin
            r_rnd_idx <= '0;
            r_blk_idx <= '0;
            r_state   <= w_next;
            if (w_next == S_DONE) begin
              r_rnd_en <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_count <= r_count + 7'd1;
            end
          end else if (w_rnd_last) begin
            r_rnd_idx <= '0;
            r_blk_idx <= r_blk_idx + 2'd1;
            r_count   <= r_count + 7'd1;
          end else begin
            r_rnd_idx <= r_rnd_idx + 4'd1;
            r_count   <= r_count + 7'd1;
          end
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign rnd_en      = r_rnd_en;
  assign core_enc    = r_enc;
  assign core_dec    = r_dec;
`ifdef ASCON_SEQ_HASH_EN
  assign core_hash   = r_hash;
`else
  assign core_hash   = 1'b0;
`endif
  assign auth_fail   = r_auth_fail;
  assign err_illegal = r_err_illegal;
  assign count       = r_count;
  assign rnd_idx     = r_rnd_idx;
  assign blk_idx     = r_blk_idx;
  assign phase       = r_state;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Directed + random bench for ascon_sequencer; expected round traces come from a phase-list model.
module tb_ascon_sequencer;
  localparam int RA  = 12;
  localparam int RB  = 6;
  localparam int NAD = 4;
  localparam int NPT = 4;
  localparam int NH  = 4;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_valid1, tag_match;
  logic [1:0] req_op;
  logic       req_ready, core_enc, core_dec, core_hash, rnd_en, busy, done, auth_fail, err_illegal;
  logic [6:0] count;
  logic [3:0] rnd_idx;
  logic [1:0] blk_idx;
  logic [2:0] phase;
  logic       req_ready1, core_enc1, core_dec1, core_hash1, rnd_en1, busy1, done1, auth_fail1, err_illegal1;
  logic [6:0] count1;
  logic [3:0] rnd_idx1;
  logic [1:0] blk_idx1;
  logic [2:0] phase1;

  always #5 clk = ~clk;

  ascon_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .tag_match(tag_match), .core_enc(core_enc), .core_dec(core_dec), .core_hash(core_hash),
    .rnd_en(rnd_en), .count(count), .rnd_idx(rnd_idx), .blk_idx(blk_idx), .phase(phase),
    .busy(busy), .done(done), .auth_fail(auth_fail), .err_illegal(err_illegal)
  );

  ascon_sequencer #(.PT_BLOCKS(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_op(req_op), .req_ready(req_ready1),
    .tag_match(tag_match), .core_enc(core_enc1), .core_dec(core_dec1), .core_hash(core_hash1),
    .rnd_en(rnd_en1), .count(count1), .rnd_idx(rnd_idx1), .blk_idx(blk_idx1), .phase(phase1),
    .busy(busy1), .done(done1), .auth_fail(auth_fail1), .err_illegal(err_illegal1)
  );

  int total = 0;
  int bad   = 0;
  int e_ph[$];
  int e_ri[$];
  int e_bi[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(input logic [1:0] op);
`ifdef ASCON_SEQ_HASH_EN
    return op == 2'b11;
`else
    return op[1];
`endif
  endfunction

  task automatic add_perm(input int p, input int nb, input int r);
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < r; i++) begin
        e_ph.push_back(p);
        e_ri.push_back(i);
        e_bi.push_back(b);
      end
  endtask

  // Expected per-cycle (phase, round, block) list for one operation.
  task automatic build(input logic [1:0] op);
    e_ph.delete(); e_ri.delete(); e_bi.delete();
    if (!is_illegal(op)) begin
      add_perm(1, 1, RA);
      if (op == 2'b10) begin
        add_perm(5, NH, RA);
        add_perm(6, 3, RA);
      end else begin
        add_perm(2, NAD, RB);
        add_perm(3, NPT - 1, RB);
        add_perm(4, 1, RA);
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic tm, input bit hold);
    int n;
    bit ill, eh;
    build(op);
    n   = e_ph.size();
    ill = is_illegal(op);
    eh  = (op == 2'b10) && !ill;
    @(negedge clk);
    check("ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_op = op; tag_match = tm;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    check("auth_cleared_on_accept", auth_fail, 0);
    check("err_illegal_on_accept", err_illegal, ill);
    for (int k = 0; k < n; k++) begin
      check("rnd_en", rnd_en, 1);
      check("count", count, k);
      check("phase", phase, e_ph[k]);
      check("rnd_idx", rnd_idx, e_ri[k]);
      check("blk_idx", blk_idx, e_bi[k]);
      check("mode", {core_enc, core_dec, core_hash}, {op == 2'b00, op == 2'b01, eh});
      check("busy_ready_done", {busy, req_ready, done}, 3'b100);
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("done_rnd_en", rnd_en, 0);
    check("done_phase", phase, 7);
    check("done_busy_ready", {busy, req_ready}, 2'b10);
    check("done_mode", {core_enc, core_dec, core_hash},
          ill ? 3'b000 : {op == 2'b00, op == 2'b01, eh});
    if (!ill) check("done_count", count, n - 1);
    req_valid = 1'b0;
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_ready_busy", {req_ready, busy}, 2'b10);
    check("idle_phase", phase, 0);
    check("idle_mode", {core_enc, core_dec, core_hash}, 3'b000);
    check("idle_auth_fail", auth_fail, (op == 2'b01) && !tm);
    check("idle_err_illegal", err_illegal, ill);
    if (!ill) check("idle_count", count, n - 1);
  endtask

  initial begin
    int ndone, first, nr;
    bit saw3;
    rst = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0; req_op = 2'b00; tag_match = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready_busy", {req_ready, busy}, 2'b10);
    check("rst_count", count, 0);
    check("rst_phase", phase, 0);
    check("rst_misc", {done, rnd_en, auth_fail, err_illegal, core_enc, core_dec, core_hash}, 0);
    check("rst_idx", {rnd_idx, blk_idx}, 0);
    rst = 1'b0;

    run_op(2'b00, 1'b1, 1'b0);
    run_op(2'b01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("auth_fail_holds", auth_fail, 1);
    run_op(2'b01, 1'b1, 1'b0);
    run_op(2'b10, 1'b1, 1'b0);
    run_op(2'b11, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("err_illegal_holds", err_illegal, 1);

    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an encrypt.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_reset_count", count, 29);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready_busy", {req_ready, busy}, 2'b10);
    check("midrst_phase_count", {phase, count}, 0);
    check("midrst_misc", {done, rnd_en, core_enc, core_dec, core_hash}, 0);
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_no_done", ndone, 0);

    // Single text block: TEXT skipped.
    req_valid1 = 1'b1; req_op = 2'b00;
    @(negedge clk);
    req_valid1 = 1'b0;
    first = -1; nr = 0; saw3 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done1 && first < 0) first = c;
      if (phase1 == 3'd3) saw3 = 1'b1;
      if (rnd_en1) nr++;
      @(negedge clk);
    end
    check("pt1_done_cycle", first, 49);
    check("pt1_no_text", saw3, 0);
    check("pt1_rounds", nr, 48);
    check("pt1_idle", {req_ready1, busy1}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
